// File: rtl/yutorina_gpr_mp_pkg.sv
// Shared defaults and constants for the multi-port register file.
package yutorina_gpr_mp_pkg;

  localparam int unsigned GPR_DATA_W = 32;
  localparam int unsigned GPR_ADDR_W = 5;
  localparam int unsigned GPR_NUM_RD = 4;
  localparam int unsigned GPR_NUM_WR = 2;
  localparam int unsigned GPR_BYPASS = 1;

  // Hard-wired zero register
  localparam int unsigned GPR_ZERO = 0;

endpackage

// File: rtl/yutorina_gpr_rd_port.sv
// One read port: zero-register check, write bypass select and busy masking.
module yutorina_gpr_rd_port
  import yutorina_gpr_mp_pkg::*;
#(
  parameter int unsigned DATA_W = GPR_DATA_W,
  parameter int unsigned ADDR_W = GPR_ADDR_W,
  parameter int unsigned NUM_WR = GPR_NUM_WR,
  parameter int unsigned BYPASS = GPR_BYPASS
) (
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        stored_data,
  input  logic                     stored_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0]        data,
  output logic                     busy
);

  logic              hit;
  logic [DATA_W-1:0] fwd;

  // Highest-indexed matching write port forwards its data; bypass is off in reset
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    for (int unsigned p = 0; p < NUM_WR; p++) begin
      if ((BYPASS != 0) && !rst && wr_en[p] &&
          (wr_addr[p*ADDR_W +: ADDR_W] == addr)) begin
        hit = 1'b1;
        fwd = wr_data[p*DATA_W +: DATA_W];
      end
    end
  end

  // Register zero reads as 0 and never busy; forwarded data is never busy
  always_comb begin
    data = '0;
    busy = 1'b0;
    if (addr != ADDR_W'(GPR_ZERO)) begin
      data = hit ? fwd : stored_data;
      busy = stored_busy & ~hit;
    end
  end

endmodule

// File: rtl/yutorina_gpr_mp.sv
// Multi-port register file with per-register busy scoreboard.
module yutorina_gpr_mp
  import yutorina_gpr_mp_pkg::*;
#(
  parameter int unsigned DATA_W = GPR_DATA_W,
  parameter int unsigned ADDR_W = GPR_ADDR_W,
  parameter int unsigned NUM_RD = GPR_NUM_RD,
  parameter int unsigned NUM_WR = GPR_NUM_WR,
  parameter int unsigned BYPASS = GPR_BYPASS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     busy_any
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;

  // Register storage: later write ports override earlier ones on collision
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < NUM_WR; p++) begin
        if (wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] != ADDR_W'(GPR_ZERO))) begin
          regs[wr_addr[p*ADDR_W +: ADDR_W]] <= wr_data[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Scoreboard: writeback clears, issue sets; a same-cycle issue supersedes the clear
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_WR; p++) begin
        if (wr_en[p]) begin
          busy[wr_addr[p*ADDR_W +: ADDR_W]] <= 1'b0;
        end
      end
      if (iss_en && (iss_addr != ADDR_W'(GPR_ZERO))) begin
        busy[iss_addr] <= 1'b1;
      end
    end
  end

  assign busy_any = |busy;

  // One combinational read port per rd_addr slice
  for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
    yutorina_gpr_rd_port #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .NUM_WR(NUM_WR),
      .BYPASS(BYPASS)
    ) u_rd (
      .rst        (rst),
      .addr       (rd_addr[k*ADDR_W +: ADDR_W]),
      .stored_data(regs[rd_addr[k*ADDR_W +: ADDR_W]]),
      .stored_busy(busy[rd_addr[k*ADDR_W +: ADDR_W]]),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .data       (rd_data[k*DATA_W +: DATA_W]),
      .busy       (rd_busy[k])
    );
  end

endmodule

// File: tb/tb_yutorina_gpr_mp.sv
// Self-checking bench: bypass and non-bypass instances share stimulus.
module tb_yutorina_gpr_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;
  localparam int NW = 2;
  localparam int NREG = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   ra [NR];
  logic            we [NW];
  logic [AW-1:0]   wa [NW];
  logic [DW-1:0]   wd [NW];
  logic            iss_en;
  logic [AW-1:0]   iss_addr;

  logic [NR*AW-1:0] rd_addr;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;

  logic [NR*DW-1:0] rd_data_b, rd_data_n;
  logic [NR-1:0]    rd_busy_b, rd_busy_n;
  logic             busy_any_b, busy_any_n;

  logic [DW-1:0] mregs [NREG];
  logic          mbusy [NREG];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NR; k++) rd_addr[k*AW +: AW] = ra[k];
    for (int p = 0; p < NW; p++) begin
      wr_en[p] = we[p];
      wr_addr[p*AW +: AW] = wa[p];
      wr_data[p*DW +: DW] = wd[p];
    end
  end

  yutorina_gpr_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_any(busy_any_b));

  yutorina_gpr_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_any(busy_any_n));

  // Reference: what a read of address a sees this cycle
  function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a, input bit bp);
    logic [DW-1:0] r;
    if (a == 0) return '0;
    r = mregs[a];
    if (bp && !rst)
      for (int p = 0; p < NW; p++)
        if (we[p] && wa[p] == a) r = wd[p];
    return r;
  endfunction

  function automatic logic m_busy(input logic [AW-1:0] a, input bit bp);
    if (a == 0) return 1'b0;
    if (bp && !rst)
      for (int p = 0; p < NW; p++)
        if (we[p] && wa[p] == a) return 1'b0;
    return mbusy[a];
  endfunction

  function automatic logic m_any();
    logic r = 1'b0;
    for (int i = 0; i < NREG; i++) r |= mbusy[i];
    return r;
  endfunction

  // Reference state update at a rising edge
  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin mregs[i] = '0; mbusy[i] = 1'b0; end
    end else begin
      for (int p = 0; p < NW; p++) begin
        if (we[p] && wa[p] != 0) mregs[wa[p]] = wd[p];
        if (we[p]) mbusy[wa[p]] = 1'b0;
      end
      if (iss_en && iss_addr != 0) mbusy[iss_addr] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; iss_en = 1'b0; iss_addr = '0;
    for (int p = 0; p < NW; p++) begin we[p] = 1'b0; wa[p] = '0; wd[p] = '0; end
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    we[0] = 1'b1; wa[0] = 5'd3; wd[0] = 32'hFFFF_FFFF;
    iss_en = 1'b1; iss_addr = 5'd3;
    tick();
    idle();
    for (int a = 0; a < NREG; a++) begin
      for (int k = 0; k < NR; k++) ra[k] = AW'(a);
      #1;
      vectors++;
      if (rd_data_b[0 +: DW] !== 32'h0 || rd_busy_b !== 4'h0 || busy_any_b !== 1'b0 ||
          rd_data_n[3*DW +: DW] !== 32'h0 || rd_busy_n !== 4'h0 || busy_any_n !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_read a=%0d data_b=%h busy_b=%b any_b=%b data_n=%h busy_n=%b any_n=%b expected 0",
                 a, rd_data_b[0 +: DW], rd_busy_b, busy_any_b, rd_data_n[3*DW +: DW], rd_busy_n, busy_any_n);
      end
    end
  endtask

  task automatic test_collision();
    idle();
    we[0] = 1'b1; wa[0] = 5'd7; wd[0] = 32'hAAAA_0000;
    we[1] = 1'b1; wa[1] = 5'd7; wd[1] = 32'h5555_FFFF;
    tick();
    idle();
    ra[0] = 5'd7; ra[1] = 5'd7;
    #1;
    vectors++;
    if (rd_data_b[0 +: DW] !== 32'h5555_FFFF || rd_data_n[DW +: DW] !== 32'h5555_FFFF) begin
      miscompares++;
      $display("FAIL collision r7 got b=%h n=%h expected 5555ffff", rd_data_b[0 +: DW], rd_data_n[DW +: DW]);
    end
    we[0] = 1'b1; wa[0] = 5'd0; wd[0] = 32'hCAFE_F00D;
    ra[0] = 5'd0;
    #1;
    vectors++;
    if (rd_data_b[0 +: DW] !== 32'h0 || rd_busy_b[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL r0_bypass got %h busy %b expected 0", rd_data_b[0 +: DW], rd_busy_b[0]);
    end
    tick();
    idle();
    ra[0] = 5'd0;
    #1;
    vectors++;
    if (rd_data_b[0 +: DW] !== 32'h0 || rd_data_n[0 +: DW] !== 32'h0) begin
      miscompares++;
      $display("FAIL r0_write got b=%h n=%h expected 0", rd_data_b[0 +: DW], rd_data_n[0 +: DW]);
    end
  endtask

  task automatic test_bypass();
    idle();
    ra[2] = 5'd3;
    we[1] = 1'b1; wa[1] = 5'd3; wd[1] = 32'h1234_5678;
    #1;
    vectors++;
    if (rd_data_b[2*DW +: DW] !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL bypass_on got %h expected 12345678", rd_data_b[2*DW +: DW]);
    end
    vectors++;
    if (rd_data_n[2*DW +: DW] !== 32'h0) begin
      miscompares++;
      $display("FAIL bypass_off got %h expected 00000000", rd_data_n[2*DW +: DW]);
    end
    tick();
    idle();
    ra[2] = 5'd3;
    #1;
    vectors++;
    if (rd_data_b[2*DW +: DW] !== 32'h1234_5678 || rd_data_n[2*DW +: DW] !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL bypass_next got b=%h n=%h expected 12345678", rd_data_b[2*DW +: DW], rd_data_n[2*DW +: DW]);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    iss_en = 1'b1; iss_addr = 5'd5;
    ra[1] = 5'd5;
    #1;
    vectors++;
    if (rd_busy_b[1] !== 1'b0 || busy_any_b !== 1'b0) begin
      miscompares++;
      $display("FAIL issue_same_cycle busy=%b any=%b expected 0 0", rd_busy_b[1], busy_any_b);
    end
    tick();
    idle();
    ra[1] = 5'd5;
    #1;
    vectors++;
    if (rd_busy_b[1] !== 1'b1 || busy_any_b !== 1'b1 || rd_busy_n[1] !== 1'b1 || busy_any_n !== 1'b1) begin
      miscompares++;
      $display("FAIL issue_busy b=%b/%b n=%b/%b expected 1/1", rd_busy_b[1], busy_any_b, rd_busy_n[1], busy_any_n);
    end
    we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'h42;
    #1;
    vectors++;
    if (rd_busy_b[1] !== 1'b0 || rd_data_b[DW +: DW] !== 32'h42) begin
      miscompares++;
      $display("FAIL wb_bypass busy=%b data=%h expected 0 00000042", rd_busy_b[1], rd_data_b[DW +: DW]);
    end
    vectors++;
    if (rd_busy_n[1] !== 1'b1 || rd_data_n[DW +: DW] !== 32'h0 || busy_any_b !== 1'b1) begin
      miscompares++;
      $display("FAIL wb_nobypass busy=%b data=%h any=%b expected 1 00000000 1", rd_busy_n[1], rd_data_n[DW +: DW], busy_any_b);
    end
    tick();
    idle();
    ra[1] = 5'd5;
    #1;
    vectors++;
    if (rd_busy_b[1] !== 1'b0 || busy_any_b !== 1'b0 || busy_any_n !== 1'b0 || rd_data_n[DW +: DW] !== 32'h42) begin
      miscompares++;
      $display("FAIL wb_clear busy=%b any=%b/%b data=%h expected 0 0/0 00000042",
               rd_busy_b[1], busy_any_b, busy_any_n, rd_data_n[DW +: DW]);
    end
  endtask

  task automatic test_race();
    idle();
    iss_en = 1'b1; iss_addr = 5'd9;
    we[1] = 1'b1; wa[1] = 5'd9; wd[1] = 32'h99;
    tick();
    idle();
    ra[3] = 5'd9;
    #1;
    vectors++;
    if (rd_data_b[3*DW +: DW] !== 32'h99 || rd_busy_b[3] !== 1'b1 || rd_busy_n[3] !== 1'b1) begin
      miscompares++;
      $display("FAIL issue_write_race data=%h busy=%b/%b expected 00000099 1/1",
               rd_data_b[3*DW +: DW], rd_busy_b[3], rd_busy_n[3]);
    end
  endtask

  task automatic test_reset_mid();
    idle();
    we[0] = 1'b1; wa[0] = 5'd4; wd[0] = 32'hDEAD;
    iss_en = 1'b1; iss_addr = 5'd6;
    tick();
    idle();
    rst = 1'b1;
    we[0] = 1'b1; wa[0] = 5'd4; wd[0] = 32'hBEEF;
    iss_en = 1'b1; iss_addr = 5'd8;
    ra[0] = 5'd4; ra[1] = 5'd6;
    #1;
    vectors++;
    if (rd_data_b[0 +: DW] !== 32'hDEAD || rd_busy_b[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL bypass_in_reset data=%h busy6=%b expected 0000dead 1", rd_data_b[0 +: DW], rd_busy_b[1]);
    end
    tick();
    idle();
    ra[0] = 5'd4; ra[1] = 5'd6; ra[2] = 5'd8;
    #1;
    vectors++;
    if (rd_data_b[0 +: DW] !== 32'h0 || rd_data_n[0 +: DW] !== 32'h0 || rd_busy_b !== 4'h0 ||
        busy_any_b !== 1'b0 || busy_any_n !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid data=%h/%h busy=%b any=%b/%b expected 0",
               rd_data_b[0 +: DW], rd_data_n[0 +: DW], rd_busy_b, busy_any_b, busy_any_n);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      for (int p = 0; p < NW; p++) begin
        we[p] = $urandom_range(0, 1);
        wa[p] = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
        wd[p] = $urandom;
      end
      iss_en = ($urandom_range(0, 2) != 0);
      iss_addr = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      for (int k = 0; k < NR; k++)
        ra[k] = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      #1;
      for (int k = 0; k < NR; k++) begin
        vectors++;
        if (rd_data_b[k*DW +: DW] !== m_rd(ra[k], 1'b1) || rd_busy_b[k] !== m_busy(ra[k], 1'b1)) begin
          miscompares++;
          $display("FAIL rand_bypass n=%0d port=%0d a=%0d got %h/%b expected %h/%b", n, k, ra[k],
                   rd_data_b[k*DW +: DW], rd_busy_b[k], m_rd(ra[k], 1'b1), m_busy(ra[k], 1'b1));
        end
        vectors++;
        if (rd_data_n[k*DW +: DW] !== m_rd(ra[k], 1'b0) || rd_busy_n[k] !== m_busy(ra[k], 1'b0)) begin
          miscompares++;
          $display("FAIL rand_nobypass n=%0d port=%0d a=%0d got %h/%b expected %h/%b", n, k, ra[k],
                   rd_data_n[k*DW +: DW], rd_busy_n[k], m_rd(ra[k], 1'b0), m_busy(ra[k], 1'b0));
        end
      end
      vectors++;
      if (busy_any_b !== m_any() || busy_any_n !== m_any()) begin
        miscompares++;
        $display("FAIL rand_busy_any n=%0d got %b/%b expected %b", n, busy_any_b, busy_any_n, m_any());
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) begin mregs[i] = '0; mbusy[i] = 1'b0; end
    for (int k = 0; k < NR; k++) ra[k] = '0;
    idle();
    #1;
    test_reset();
    test_collision();
    test_bypass();
    test_scoreboard();
    test_race();
    test_reset_mid();
    test_random();
    test_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/yutorina_gpr_mp.md
Name: yutorina_gpr_mp

Overview:
Parametrised multi-port general-purpose register file with a built-in register scoreboard, for the multi-issue successor to the current single-issue core. It provides NUM_RD combinational read ports and NUM_WR write ports, with optional write-to-read bypass. A per-register busy bit is set when an instruction issues and cleared on writeback. Decode uses the busy flags for hazard stalls; writeback drives the write ports.

Parameters:
DATA_W, 32, width of each register in bits.
ADDR_W, 5, register address width; register count is 2**ADDR_W.
NUM_RD, 4, number of read ports (1..8).
NUM_WR, 2, number of write ports (1..4).
BYPASS, 1, 1 = a same-cycle write is visible on read ports; 0 = reads return the pre-write value.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, synchronous, active-high.
rd_addr  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
rd_data  out  NUM_RD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W].
rd_busy  out  NUM_RD  busy flag of the register addressed by each read port.
wr_en  in  NUM_WR  write enable per write port, active-high.
wr_addr  in  NUM_WR*ADDR_W  write addresses, packed as for rd_addr.
wr_data  in  NUM_WR*DATA_W  write data, packed as for rd_data.
iss_en  in  1  issue strobe: mark iss_addr busy.
iss_addr  in  ADDR_W  destination register of the issuing instruction.
busy_any  out  1  OR of all busy bits.

Behaviour:
- Storage: 2**ADDR_W registers of DATA_W bits, plus a busy vector of 2**ADDR_W bits.
- Register 0 always reads 0 and its busy bit always reads 0. Writes and issues to register 0 are ignored.
- Reset: on a rising edge with rst=1, every register becomes 0 and every busy bit becomes 0. On that edge, wr_en and iss_en are ignored.
- After the reset edge, rd_data = 0, rd_busy = 0 and busy_any = 0 until the next write or issue.
- Write: on a rising edge with rst=0, for each port p with wr_en[p]=1 and a nonzero address, the register takes wr_data[p].
- Write collision: when several enabled ports target the same address, the highest-indexed port wins.
- Read latency is 0 (combinational) from rd_addr.
- BYPASS=1: if any enabled write port targets the read address (nonzero) in the same cycle, rd_data returns that port's wr_data; the highest-indexed matching port wins. Otherwise rd_data returns the stored value. Bypass is active only when rst=0.
- BYPASS=0: rd_data returns the stored value, i.e. the old value during a same-cycle write.
- Scoreboard clear: on a rising edge, busy[a] is cleared for every enabled write port with address a.
- Scoreboard set: on a rising edge, busy[iss_addr] is set when iss_en=1 and iss_addr != 0.
- Issue and write to the same address in the same cycle: the set wins, because the new producer supersedes the old one. The data write still occurs.
- rd_busy follows BYPASS:
  - BYPASS=1: rd_busy is masked to 0 when a same-cycle write matches the read address, since that data is forwarded.
  - BYPASS=0: rd_busy reflects the stored busy bit only.
- rd_busy never reflects a same-cycle issue; the bit appears from the next cycle.
- busy_any is combinational from the stored busy vector.
- An out-of-range or X address is not legal stimulus; the model need not define its result.

Decomposition:
- Shared header/package gpr_mp.h holds:
  - defaults for DATA_W, ADDR_W, NUM_RD, NUM_WR;
  - GPR_ZERO address constant;
  - pack/unpack slice macros for the flattened port buses.
- One natural sub-module, yutorina_gpr_rd_port. It handles a single read port's zero-check, bypass-select and busy-mask logic, and is instantiated NUM_RD times in a generate loop.
- The storage and scoreboard stay in the top module.

Test Plan:
1. Reset then reads: pulse rst for 1 edge; read every address -> rd_data=0, rd_busy=0, busy_any=0.
2. Dual write collision: wr_en=2'b11, both ports addr 7, data 0xAAAA0000 (p0) / 0x5555FFFF (p1). Next cycle read r7 -> 0x5555FFFF. Write to r0 -> r0 still reads 0.
3. Bypass: BYPASS=1, write r3=0x12345678 while rd_addr=3 in the same cycle -> rd_data=0x12345678 that cycle. With BYPASS=0 -> old value 0 that cycle, 0x12345678 the next cycle.
4. Scoreboard lifecycle:
   - Issue r5 -> next cycle rd_busy=1, busy_any=1.
   - Write r5=0x42 -> same cycle rd_busy=0 (BYPASS=1), rd_data=0x42.
   - Next cycle -> busy clear, busy_any=0.
5. Issue/write race: same cycle iss_addr=9 and write r9=0x99 -> next cycle r9 reads 0x99 and rd_busy=1.
6. Reset mid-operation: r4=0xDEAD and busy[6]=1, then assert rst together with wr_en (r4=0xBEEF) and iss_en (r8) -> after the edge, r4=0, busy vector all 0.
